// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI-stream sink between NUM_SRC sources.
// Grants last up to BURST_LEN beats and end early on source stall or disable.
module axis_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 256,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = $clog2(NUM_SRC)
) (
  input  logic                      axis_aclk,
  input  logic                      axis_rstb,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [ID_W-1:0]           m_axis_tuser,
  output logic                      busy,
  output logic [ID_W-1:0]           gnt_id
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] GRANT     = 1'b1;
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [0:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [7:0]         beat_cnt;
  logic [NUM_SRC-1:0] req;
  logic               req_any;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    idx;
  logic               found;
  logic               gnt_ready;
  logic               src_load;
  logic               out_fire;
  logic               release_gnt;
  logic [DATA_W-1:0]  sel_data;
  logic               vld_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [ID_W-1:0]    user_p1;

  assign req     = s_axis_tvalid & src_en;
  assign req_any = |req;

  // Search upward from the source after the last winner, wrapping at NUM_SRC.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign gnt_ready   = (state == GRANT) && src_en[gnt_id] && (!vld_p1 || m_axis_tready);
  assign src_load    = gnt_ready && s_axis_tvalid[gnt_id];
  assign out_fire    = vld_p1 && m_axis_tready;
  assign release_gnt = (src_load && (beat_cnt == LAST_BEAT)) ||
                       !s_axis_tvalid[gnt_id] || !src_en[gnt_id];
  assign sel_data    = s_axis_tdata[int'(gnt_id) * DATA_W +: DATA_W];
  assign busy        = (state == GRANT);

  always_comb begin
    s_axis_tready         = '0;
    s_axis_tready[gnt_id] = gnt_ready;
  end

  always_ff @(posedge axis_aclk or negedge axis_rstb) begin
    if (!axis_rstb) begin
      state    <= IDLE;
      rr_ptr   <= ID_W'(NUM_SRC - 1);
      beat_cnt <= '0;
      gnt_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt_id   <= pick;
            rr_ptr   <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        default: begin
          if (src_load) beat_cnt <= beat_cnt + 8'd1;
          if (release_gnt) state <= IDLE;
        end
      endcase
    end
  end

  // Stage p1: output register; a held beat is dropped on reset.
  always_ff @(posedge axis_aclk or negedge axis_rstb) begin
    if (!axis_rstb) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      user_p1 <= '0;
    end else if (src_load) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      user_p1 <= gnt_id;
    end else if (out_fire) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tuser  = user_p1;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: queue-driven sources, scoreboard on the sink side.
module tb_axis_rr_arbiter;
  localparam int NUM_SRC   = 4;
  localparam int DATA_W    = 256;
  localparam int BURST_LEN = 4;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      axis_rstb;
  logic [NUM_SRC-1:0]        src_en;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic [ID_W-1:0]           m_axis_tuser;
  logic                      busy;
  logic [ID_W-1:0]           gnt_id;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ID_W(ID_W)
  ) dut (
    .axis_aclk(clk), .axis_rstb(axis_rstb), .src_en(src_en),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .busy(busy), .gnt_id(gnt_id)
  );

  typedef struct packed {
    logic [ID_W-1:0]   user;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             exp_q[$];
  beat_t             mon_b;
  logic [DATA_W-1:0] src_q [NUM_SRC][$];
  int                hs_cnt [NUM_SRC];
  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  int                grants = 0;
  logic              busy_q = 1'b0;
  bit                gap_chk = 1'b0;
  bit                have_last = 1'b0;
  int                last_cyc = 0;
  logic [ID_W-1:0]   last_user = '0;
  bit                hold_pend = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;
  int                n;
  int                k;

  function automatic logic [DATA_W-1:0] mk(input int s, input int i);
    logic [31:0] w;
    w = 32'(s * 65536 + i) ^ 32'hA500_0000;
    return {8{w}};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int s, input int first, input int cnt);
    for (int i = 0; i < cnt; i++) src_q[s].push_back(mk(s, first + i));
  endtask

  task automatic expect_beats(input int s, input int first, input int cnt);
    beat_t b;
    for (int i = 0; i < cnt; i++) begin
      b.user = ID_W'(s);
      b.data = mk(s, first + i);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    axis_rstb = 1'b0;
    repeat (2) @(negedge clk);
    axis_rstb = 1'b1;
    grants    = 0;
    busy_q    = 1'b0;
    have_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) hs_cnt[i] = 0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d beats missing after %0d cycles, expected 0", name, exp_q.size(), max);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Source models: present queue head, pop on handshake sampled just before the edge.
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        s_axis_tvalid[i] = (src_q[i].size() > 0);
        s_axis_tdata[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
      #1;
      check("ready_onehot", DATA_W'($countones(s_axis_tready) <= 1), DATA_W'(1));
      for (int i = 0; i < NUM_SRC; i++) begin
        if (s_axis_tvalid[i] && s_axis_tready[i]) begin
          void'(src_q[i].pop_front());
          hs_cnt[i]++;
        end
      end
    end
  end

  // Sink monitor and scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (busy && !busy_q) grants++;
      busy_q = busy;
      if (!axis_rstb) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", DATA_W'(m_axis_tvalid), DATA_W'(1));
          check("hold_data", m_axis_tdata, hold_data);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got tuser %0d data %0h, expected no beat", m_axis_tuser, m_axis_tdata);
          end else begin
            mon_b = exp_q.pop_front();
            check("tuser", DATA_W'(m_axis_tuser), DATA_W'(mon_b.user));
            check("tdata", m_axis_tdata, mon_b.data);
            if (gap_chk && have_last) begin
              if (m_axis_tuser == last_user) check("gap_in_burst", DATA_W'(cyc - last_cyc), DATA_W'(1));
              else check("gap_between_bursts", DATA_W'(cyc - last_cyc), DATA_W'(2));
            end
            have_last = 1'b1;
            last_cyc  = cyc;
            last_user = m_axis_tuser;
          end
        end
        hold_pend = m_axis_tvalid && !m_axis_tready;
        hold_data = m_axis_tdata;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_rstb     = 1'b0;
    src_en        = 4'hF;
    m_axis_tready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) hs_cnt[i] = 0;

    // Reset values, then idle with no requests.
    repeat (3) @(negedge clk);
    #2;
    check("rst_tvalid", DATA_W'(m_axis_tvalid), '0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tuser", DATA_W'(m_axis_tuser), '0);
    check("rst_gnt_id", DATA_W'(gnt_id), '0);
    check("rst_busy", DATA_W'(busy), '0);
    check("rst_tready", DATA_W'(s_axis_tready), '0);
    @(negedge clk);
    axis_rstb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      check("idle_tvalid", DATA_W'(m_axis_tvalid), '0);
      check("idle_tready", DATA_W'(s_axis_tready), '0);
      check("idle_busy", DATA_W'(busy), '0);
    end

    // Fair bursts between sources 0 and 2.
    do_reset();
    gap_chk = 1'b1;
    send(0, 0, 8);
    send(2, 0, 8);
    expect_beats(0, 0, 4);
    expect_beats(2, 0, 4);
    expect_beats(0, 4, 4);
    expect_beats(2, 4, 4);
    wait_drain("fair", 200);
    gap_chk = 1'b0;
    check("fair_grants", DATA_W'(grants), DATA_W'(4));

    // Source 1 stalls after 3 beats; source 3 follows after one idle cycle.
    do_reset();
    send(1, 0, 3);
    send(3, 0, 4);
    expect_beats(1, 0, 3);
    expect_beats(3, 0, 4);
    n = 0;
    @(negedge clk);
    while (hs_cnt[1] < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_wait", DATA_W'(hs_cnt[1]), DATA_W'(3));
    #2;
    check("stall_busy", DATA_W'(busy), DATA_W'(1));
    check("stall_gnt", DATA_W'(gnt_id), DATA_W'(1));
    @(negedge clk);
    #2;
    check("stall_bubble", DATA_W'(busy), '0);
    @(negedge clk);
    #2;
    check("stall_next_busy", DATA_W'(busy), DATA_W'(1));
    check("stall_next_gnt", DATA_W'(gnt_id), DATA_W'(3));
    wait_drain("stall", 100);
    check("stall_grants", DATA_W'(grants), DATA_W'(2));

    // Backpressure 1-0-0 while source 0 streams 32 beats.
    do_reset();
    send(0, 0, 32);
    expect_beats(0, 0, 32);
    k = 0;
    while (exp_q.size() != 0 && k < 600) begin
      @(negedge clk);
      m_axis_tready = (k % 3 == 0);
      k++;
    end
    m_axis_tready = 1'b1;
    wait_drain("backpressure", 10);
    check("bp_grants", DATA_W'(grants), DATA_W'(32 / BURST_LEN));

    // Enable mask: drop src_en[1] on source 1's second beat.
    do_reset();
    for (int s = 0; s < NUM_SRC; s++) send(s, 0, 4);
    expect_beats(0, 0, 4);
    expect_beats(1, 0, 1);
    expect_beats(2, 0, 4);
    expect_beats(3, 0, 4);
    expect_beats(1, 1, 3);
    n = 0;
    @(negedge clk);
    while (hs_cnt[1] < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    src_en = 4'b1101;
    #2;
    check("en_wait", DATA_W'(hs_cnt[1]), DATA_W'(1));
    check("en_ready_drop", DATA_W'(s_axis_tready), '0);
    check("en_gnt", DATA_W'(gnt_id), DATA_W'(1));
    @(negedge clk);
    #2;
    check("en_release", DATA_W'(busy), '0);
    @(negedge clk);
    #2;
    check("en_next_busy", DATA_W'(busy), DATA_W'(1));
    check("en_next_gnt", DATA_W'(gnt_id), DATA_W'(2));
    n = 0;
    while (src_q[3].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    #2;
    check("en_skip_busy", DATA_W'(busy), '0);
    check("en_skip_tready", DATA_W'(s_axis_tready), '0);
    check("en_skip_pending", DATA_W'(exp_q.size()), DATA_W'(3));
    @(negedge clk);
    src_en = 4'hF;
    wait_drain("enable", 100);
    check("en_grants", DATA_W'(grants), DATA_W'(5));

    // Reset while a beat is held by output backpressure.
    do_reset();
    m_axis_tready = 1'b0;
    send(0, 0, 2);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!m_axis_tvalid && n < 20);
    check("rstmid_setup", DATA_W'(m_axis_tvalid), DATA_W'(1));
    #1;
    axis_rstb = 1'b0;
    #1;
    check("rstmid_tvalid", DATA_W'(m_axis_tvalid), '0);
    check("rstmid_tdata", m_axis_tdata, '0);
    check("rstmid_tready", DATA_W'(s_axis_tready), '0);
    check("rstmid_busy", DATA_W'(busy), '0);
    check("rstmid_src_left", DATA_W'(src_q[0].size()), DATA_W'(1));
    send(2, 0, 1);
    repeat (2) @(negedge clk);
    axis_rstb     = 1'b1;
    m_axis_tready = 1'b1;
    grants        = 0;
    busy_q        = 1'b0;
    expect_beats(0, 1, 1);
    expect_beats(2, 0, 1);
    @(negedge clk);
    #2;
    check("rstmid_first_busy", DATA_W'(busy), DATA_W'(1));
    check("rstmid_first_gnt", DATA_W'(gnt_id), '0);
    wait_drain("rstmid", 50);
    check("rstmid_grants", DATA_W'(grants), DATA_W'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
